// File: rtl/alu_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// alu_sequencer_pkg
//   Shared definitions for the ALU front-end sequencer: the FSM state
//   encoding, which raw push-button does what, and which bit of the ALU
//   load strobe belongs to which ALU register.
//
//   Contents:
//     state_t      - FSM states (WAIT_A, WAIT_B, WAIT_OP, SHOW)
//     BTN_*        - push-button index constants
//     VLD_*        - bit positions inside the 3-bit load strobe
//     LOAD_*       - ready-made one-hot strobe values
//     step_onehot  - maps a state to its one-hot LED pattern
// ---------------------------------------------------------------------------
package alu_sequencer_pkg;

  // Width of the one-hot load strobe and of the LED step indicator.
  localparam int NB_VALID = 3;
  localparam int NB_STEP  = 4;

  // FSM states, in the order the operator walks through them.
  typedef enum logic [1:0] {
    ST_WAIT_A  = 2'd0,
    ST_WAIT_B  = 2'd1,
    ST_WAIT_OP = 2'd2,
    ST_SHOW    = 2'd3
  } state_t;

  // Push-button roles; any other index is debounced but ignored.
  localparam int BTN_NEXT  = 0;
  localparam int BTN_ABORT = 1;

  // Bit positions inside the ALU load strobe.
  localparam int VLD_A  = 0;
  localparam int VLD_B  = 1;
  localparam int VLD_OP = 2;

  localparam logic [NB_VALID-1:0] LOAD_NONE = '0;
  localparam logic [NB_VALID-1:0] LOAD_A    = NB_VALID'(1 << VLD_A);
  localparam logic [NB_VALID-1:0] LOAD_B    = NB_VALID'(1 << VLD_B);
  localparam logic [NB_VALID-1:0] LOAD_OP   = NB_VALID'(1 << VLD_OP);

  // LED pattern for a state: bit n lit while the FSM sits in state n.
  function automatic logic [NB_STEP-1:0] step_onehot(input state_t st);
    step_onehot = NB_STEP'(1) << st;
  endfunction

endpackage

// File: rtl/alu_sequencer_btn_debounce.sv
// ---------------------------------------------------------------------------
// alu_sequencer_btn_debounce
//   Conditions one raw, asynchronous, active-high push-button:
//   two-flop synchroniser, counter-based debouncer, rising-edge detector.
//
//   The debounced level only follows the synchronised input after the two
//   have disagreed for DEBOUNCE_CYCLES consecutive clocks. Any cycle where
//   they agree again restarts the count, so contact bounce never gets
//   through. The edge pulse is registered together with the level change,
//   which makes the raw-stable-to-pulse latency 2 + DEBOUNCE_CYCLES cycles
//   and the first cycle the pulse can be used one cycle after that.
//
//   Parameters:
//     DEBOUNCE_CYCLES - stable cycles needed before the level changes
//     NB_DEBOUNCE     - counter width, 2**NB_DEBOUNCE > DEBOUNCE_CYCLES
//
//   Ports:
//     i_clock  in   system clock
//     i_reset  in   asynchronous active-low reset
//     i_btn    in   raw button
//     o_level  out  debounced button level
//     o_pulse  out  one-cycle pulse on a debounced 0->1 transition
// ---------------------------------------------------------------------------
module alu_sequencer_btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int NB_DEBOUNCE     = 20
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_btn,
  output logic o_level,
  output logic o_pulse
);

  localparam logic [NB_DEBOUNCE-1:0] COUNT_LAST = NB_DEBOUNCE'(DEBOUNCE_CYCLES - 1);
  localparam logic [NB_DEBOUNCE-1:0] COUNT_ONE  = NB_DEBOUNCE'(1);

  logic                   sync_meta;
  logic                   sync_q;
  logic [NB_DEBOUNCE-1:0] count;

  // Two-flop synchroniser; the first stage may go metastable, only the
  // second stage is looked at by the debouncer.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      sync_meta <= 1'b0;
      sync_q    <= 1'b0;
    end else begin
      sync_meta <= i_btn;
      sync_q    <= sync_meta;
    end
  end

  // Debounce counter and level. The counter clears instead of wrapping:
  // either the input went back to the current level, or it stayed away
  // long enough and the level was updated.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      count   <= '0;
      o_level <= 1'b0;
      o_pulse <= 1'b0;
    end else begin
      o_pulse <= 1'b0;
      if (sync_q == o_level) begin
        count <= '0;
      end else if (count == COUNT_LAST) begin
        o_level <= sync_q;
        o_pulse <= sync_q;
        count   <= '0;
      end else begin
        count <= count + COUNT_ONE;
      end
    end
  end

endmodule

// File: rtl/alu_sequencer.sv
// ---------------------------------------------------------------------------
// alu_sequencer
//   Front-end controller between the board pins and the ALU. Buttons are
//   synchronised and debounced, then a four-step FSM walks the operator
//   through loading operand A, operand B and the opcode, and finally shows
//   the result. Each load drives the switch value onto o_data and fires a
//   single-cycle one-hot strobe on o_valid for the matching ALU register.
//
//   Parameters:
//     NB_DATA         - switch / ALU data width
//     NB_BTN          - number of raw push-buttons
//     DEBOUNCE_CYCLES - stable cycles needed before a button level changes
//     NB_DEBOUNCE     - debounce counter width
//
//   Ports:
//     i_clock  in   system clock (100 MHz board clock)
//     i_reset  in   asynchronous active-low reset
//     i_btn    in   raw buttons, [0]=next, [1]=abort, others unused
//     i_sw     in   raw switches, static while a button is pressed
//     o_data   out  registered switch value for the ALU data input
//     o_valid  out  one-hot load strobe: [0]=A, [1]=B, [2]=opcode
//     o_step   out  one-hot FSM state for the LEDs
// ---------------------------------------------------------------------------
module alu_sequencer
  import alu_sequencer_pkg::*;
#(
  parameter int NB_DATA         = 4,
  parameter int NB_BTN          = 4,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int NB_DEBOUNCE     = 20
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic [NB_BTN-1:0]   i_btn,
  input  logic [NB_DATA-1:0]  i_sw,
  output logic [NB_DATA-1:0]  o_data,
  output logic [NB_VALID-1:0] o_valid,
  output logic [NB_STEP-1:0]  o_step
);

  logic [NB_BTN-1:0] btn_level;
  logic [NB_BTN-1:0] btn_pulse;
  logic              next_pulse;
  logic              abort_pulse;
  logic              unused_btn_bits;
  state_t            state;

  // Every button gets the same conditioning, including the spare ones, so
  // that adding a function to a spare button later only touches the FSM.
  for (genvar g = 0; g < NB_BTN; g++) begin : g_btn
    alu_sequencer_btn_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .NB_DEBOUNCE     (NB_DEBOUNCE)
    ) u_debounce (
      .i_clock (i_clock),
      .i_reset (i_reset),
      .i_btn   (i_btn[g]),
      .o_level (btn_level[g]),
      .o_pulse (btn_pulse[g])
    );
  end

  assign next_pulse      = btn_pulse[BTN_NEXT];
  assign abort_pulse     = btn_pulse[BTN_ABORT];
  assign unused_btn_bits = ^{btn_level, btn_pulse};

  // Load sequencer. Abort is tested first so it wins over a simultaneous
  // next. The strobe defaults to zero every cycle, which keeps it to a
  // single cycle per load; o_data is only written on a load so it stays
  // put through SHOW, aborts and the wrap back to WAIT_A.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state   <= ST_WAIT_A;
      o_data  <= '0;
      o_valid <= LOAD_NONE;
      o_step  <= step_onehot(ST_WAIT_A);
    end else begin
      o_valid <= LOAD_NONE;
      if (abort_pulse) begin
        state  <= ST_WAIT_A;
        o_step <= step_onehot(ST_WAIT_A);
      end else if (next_pulse) begin
        case (state)
          ST_WAIT_A: begin
            o_data  <= i_sw;
            o_valid <= LOAD_A;
            state   <= ST_WAIT_B;
            o_step  <= step_onehot(ST_WAIT_B);
          end
          ST_WAIT_B: begin
            o_data  <= i_sw;
            o_valid <= LOAD_B;
            state   <= ST_WAIT_OP;
            o_step  <= step_onehot(ST_WAIT_OP);
          end
          ST_WAIT_OP: begin
            o_data  <= i_sw;
            o_valid <= LOAD_OP;
            state   <= ST_SHOW;
            o_step  <= step_onehot(ST_SHOW);
          end
          default: begin
            state  <= ST_WAIT_A;
            o_step <= step_onehot(ST_WAIT_A);
          end
        endcase
      end
    end
  end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
Front-end controller that sequences operand and opcode loading into the board-level ALU from raw push-buttons and switches. It synchronises and debounces the buttons and runs a four-step FSM (A, B, OP, show result). It drives the ALU's data bus with a single-cycle one-hot valid strobe and exposes the current step for LED status. It sits between the board pins and the ALU, replacing the direct button-to-valid wiring.

Parameters:
NB_DATA, 4, width of the switch/data bus forwarded to the ALU.
NB_BTN, 4, number of raw push-buttons.
DEBOUNCE_CYCLES, 1000000, consecutive stable cycles required before a debounced level changes (10 ms at 100 MHz).
NB_DEBOUNCE, 20, counter width; must satisfy 2^NB_DEBOUNCE > DEBOUNCE_CYCLES.

Ports:
i_clock  input  1  system clock (100 MHz board clock).
i_reset  input  1  asynchronous, active-low reset.
i_btn  input  NB_BTN  raw asynchronous push-buttons, active-high; [0]=next, [1]=abort, others unused.
i_sw  input  NB_DATA  raw switches; static during a press.
o_data  output  NB_DATA  registered switch value, to ALU i_data.
o_valid  output  3  one-hot load strobe, to ALU i_valid: [0]=A, [1]=B, [2]=opcode.
o_step  output  4  one-hot FSM state for LEDs: [0]=WAIT_A, [1]=WAIT_B, [2]=WAIT_OP, [3]=SHOW.

Behaviour:
- Reset (i_reset=0, asynchronous assert, synchronous release by design of board): o_data=0, o_valid=3'b000, o_step=4'b0001, all sync flops, debounced levels and counters = 0, FSM = WAIT_A. Reset mid-sequence discards progress; no strobe emitted.
- Per button: 2-flop synchroniser -> debouncer -> rising-edge detector.
- Debouncer: counter clears whenever synced level == debounced level. Otherwise it increments. When it reaches DEBOUNCE_CYCLES-1 with levels still differing, the debounced level takes the synced level and the counter clears.
- Edge pulse: exactly one cycle, on a debounced 0->1 transition. Held button gives one pulse. Release gives none.
- Press latency (raw stable high to edge pulse): 2 sync + DEBOUNCE_CYCLES + 1 cycles.
- FSM transitions, evaluated on edge pulses in cycle t, all effects registered at t+1:
  WAIT_A + next: o_data<=i_sw(t), o_valid<=001, -> WAIT_B.
  WAIT_B + next: o_data<=i_sw(t), o_valid<=010, -> WAIT_OP.
  WAIT_OP + next: o_data<=i_sw(t), o_valid<=100, -> SHOW.
  SHOW + next: -> WAIT_A, no strobe, o_data held.
  Any state + abort: -> WAIT_A, no strobe, o_data held.
- Abort and next pulses in the same cycle: abort wins.
- o_valid is high for exactly one cycle per accepted load and is 000 otherwise. o_data is stable in the strobe cycle and until the next load.
- Unused buttons are synchronised and debounced but ignored by the FSM.
- No arithmetic beyond the counter. The counter saturates logic by clearing and never wraps.

Decomposition:
- Shared package/header: FSM state localparams (ST_WAIT_A=0, ST_WAIT_B=1, ST_WAIT_OP=2, ST_SHOW=3), button index constants (BTN_NEXT=0, BTN_ABORT=1), valid bit indices (VLD_A, VLD_B, VLD_OP).
- Sub-module btn_debounce: one raw input, outputs debounced level and rising-edge pulse. Parameterised by DEBOUNCE_CYCLES/NB_DEBOUNCE, same clock/reset. Instantiated NB_BTN times via generate.
- The top_level wrapper instantiates alu_sequencer in front of the ALU.

Test Plan (DEBOUNCE_CYCLES=4, NB_DEBOUNCE=3):
1. Hold i_reset=0 with i_btn=4'b0011, i_sw=4'hF -> o_data=0, o_valid=000, o_step=0001 throughout. After release with no presses, outputs unchanged.
2. sw=5, btn0 high 10 cycles -> single cycle o_valid=001, o_data=5, then o_step=0010. sw=3, press -> o_valid=010, o_data=3, o_step=0100. sw=A, press -> o_valid=100, o_data=A, o_step=1000. Press again -> o_step=0001, o_valid stays 000, o_data=A.
3. Bounce: btn0 toggling every 2 cycles for 20 cycles, then low -> no strobe, o_step unchanged. Then btn0 stable high -> exactly one strobe, at 7 cycles after it goes stable.
4. Hold btn0 high 100 cycles in WAIT_A -> exactly one advance to WAIT_B and one o_valid=001 pulse.
5. In WAIT_OP press btn1 -> o_step=0001, no strobe. In WAIT_B press btn0 and btn1 on the same cycle -> o_step=0001, no strobe.
6. In WAIT_B, assert i_reset=0 mid-cycle -> o_step=0001, o_data=0, o_valid=000 immediately, before the next clock edge.
